aes_decrypt_pipe: RTL



---
 rtl/aes_decrypt_pipe.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt_pipe.sv
// Iterative 3-stage AES inverse-cipher ring (AES-128/192/256) feeding a valid/ready output FIFO.
// Define AES_DEC_CBC_EN to add CBC chaining (cbc_mode, iv_load, iv ports).

module aes_decrypt_pipe #(
    parameter int NUM_ROUNDS = 10,
    parameter int OUT_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   key_addr,
    input  logic [127:0] key_data,
    input  logic [127:0] key_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         idle
`ifdef AES_DEC_CBC_EN
    ,
    input  logic         cbc_mode,
    input  logic         iv_load,
    input  logic [127:0] iv
`endif
);

    localparam int          PW       = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [3:0]  NR       = 4'(NUM_ROUNDS);
    localparam logic [3:0]  LAST     = 4'(NUM_ROUNDS - 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(OUT_DEPTH);

    if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
        $error("aes_decrypt_pipe: NUM_ROUNDS must be 10, 12 or 14");
    end
    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("aes_decrypt_pipe: OUT_DEPTH must be a power of 2, at least 2");
    end

    typedef struct packed {
        logic         valid;
        logic [3:0]   rnd;
        logic [127:0] data;
`ifdef AES_DEC_CBC_EN
        logic [127:0] cv;
`endif
    } slot_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine, then multiplicative inverse as b^254 (maps 0 to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        logic [7:0] r;
        b = '0;
        for (int unsigned i = 0; i < 8; i++)
            b[i] = s[(i + 2) % 8] ^ s[(i + 5) % 8] ^ s[(i + 7) % 8];
        b = b ^ 8'h05;
        r = b;
        for (int unsigned i = 0; i < 6; i++)
            r = gf_mul(gf_mul(r, r), b);
        return gf_mul(r, r);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                o[127 - 8 * (r + 4 * c) -: 8] = inv_sbox(s[127 - 8 * (r + 4 * ((c + 4 - r) % 4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    slot_t         sa, sb, sc, mx, a_next, b_next, c_next;
    logic          retire, pop, push, full, stall, from_input, accept;
    logic [3:0]    key_hold;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [127:0]  mem [OUT_DEPTH];
    logic [127:0]  fifo_din;
`ifdef AES_DEC_CBC_EN
    logic [127:0]  chain;
`endif

    always_comb begin
        retire     = sc.valid && (sc.rnd == NR);
        pop        = out_valid && out_ready;
        full       = (count == FULL_CNT);
        push       = retire && (!full || pop);
        stall      = retire && full && !pop;
        from_input = !sc.valid || retire;
        in_ready   = !stall && from_input;
        accept     = in_valid && in_ready;

        mx = sc;
        if (from_input) begin
            mx.valid = accept;
            mx.rnd   = '0;
            mx.data  = in_block;
`ifdef AES_DEC_CBC_EN
            mx.cv    = iv_load ? iv : chain;
`endif
        end
        // Key store answers one cycle late, so the address must not move while the ring is frozen.
        key_addr = stall ? key_hold : (LAST - mx.rnd);

        a_next      = mx;
        a_next.data = inv_shift_sub(mx.data ^ ((mx.rnd == '0) ? key_last : '0));
        b_next      = sa;
        b_next.data = sa.data ^ key_data;
        c_next      = sb;
        c_next.data = (sb.rnd == LAST) ? sb.data : inv_mix(sb.data);
        c_next.rnd  = sb.rnd + 4'd1;

        fifo_din = sc.data;
`ifdef AES_DEC_CBC_EN
        if (cbc_mode) fifo_din = sc.data ^ sc.cv;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            sc       <= '0;
            key_hold <= '0;
        end else begin
            key_hold <= key_addr;
            if (!stall) begin
                sa <= a_next;
                sb <= b_next;
                sc <= c_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_din;
    end

`ifdef AES_DEC_CBC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          chain <= '0;
        else if (accept)  chain <= in_block;
        else if (iv_load) chain <= iv;
    end
`endif

    assign out_valid = (count != '0);
    assign out_block = out_valid ? mem[rd_ptr] : '0;
    assign idle      = !sa.valid && !sb.valid && !sc.valid && !out_valid;

endmodule
